// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: FIFO-buffered 8N1 UART transmitter for the ASCII status line.
// Define ASCII_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module ascii_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_tx,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_busy,
  output logic                  o_overflow
);
  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW    = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam int NW    = ADDR_WIDTH + 1;
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef ASCII_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]         count_q, count_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  state_t                state_q, state_d;
  logic                  tx_q, tx_d, busy_q, busy_d, full_q, full_d;
  logic                  empty_q, empty_d, ovf_q, ovf_d;
  logic                  pop, wr, tick, last_bit;
`ifdef ASCII_UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif
  always_comb begin
    pop      = (state_q == IDLE) && (count_q != '0);
    // count MSB is set only when the FIFO holds exactly DEPTH entries
    wr       = i_push && (!count_q[ADDR_WIDTH] || pop);
    tick     = cnt_q == CW'(DIV - 1);
    last_bit = bit_q == BW'(DATA_WIDTH - 1);
    count_d  = count_q + NW'(wr) - NW'(pop);
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop);
    ovf_d    = ovf_q | (i_push & ~wr);
    cnt_d    = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
`ifdef ASCII_UART_TX_PARITY_EN
    par_d    = pop ? ^mem_q[rd_ptr_q] : par_q;
`endif
    case (state_q)
      IDLE:  if (pop) begin
        state_d = START;
        shift_d = mem_q[rd_ptr_q];
        bit_d   = '0;
      end
      START: if (tick) state_d = DATA;
      DATA:  if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + BW'(1);
`ifdef ASCII_UART_TX_PARITY_EN
        if (last_bit) state_d = PARITY;
`else
        if (last_bit) state_d = STOP;
`endif
      end
`ifdef ASCII_UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_d    = (state_d == START) ? 1'b0 :
              (state_d == DATA)  ? shift_d[0] :
`ifdef ASCII_UART_TX_PARITY_EN
              (state_d == PARITY) ? par_d :
`endif
              1'b1;
    busy_d  = state_d != IDLE;
    full_d  = count_d[ADDR_WIDTH];
    empty_d = count_d == '0;
  end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_ptr_q] <= i_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
`ifdef ASCII_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
`ifdef ASCII_UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end
  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_ascii_uart_tx.sv
// tb_ascii_uart_tx: vector table, corner sequences and random traffic against a timeline model.
module tb_ascii_uart_tx;
  localparam int DW = 8;
  localparam int DIV = 10;
  localparam int DEPTH = 16;
`ifdef ASCII_UART_TX_PARITY_EN
  localparam int FB = DW + 3;
`else
  localparam int FB = DW + 2;
`endif
  localparam int FL = FB * DIV;
  logic clk = 1'b0, rst = 1'b0, i_push = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic o_tx, o_full, o_empty, o_busy, o_overflow;
  ascii_uart_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .CLK_FREQ(1000), .BAUD(100)) dut (
    .clk(clk), .rst(rst), .i_push(i_push), .i_data(i_data), .o_tx(o_tx),
    .o_full(o_full), .o_empty(o_empty), .o_busy(o_busy), .o_overflow(o_overflow));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_rx[$];
  bit m_act = 0, m_ovf = 0;
  int m_p = 0;
  logic [DW-1:0] m_byte = '0;
  bit rx_on = 0;
  int rx_t = 0, rx_n = 0;
  logic [DW-1:0] rx_b = '0, rx_last = '0;
  typedef struct { int off; logic tx; logic busy; logic empty; } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask
  function automatic logic model_tx();
    int k;
    if (!m_act || cyc - m_p >= FL) return 1'b1;
    k = (cyc - m_p) / DIV;
    if (k == 0) return 1'b0;
    if (k <= DW) return m_byte[k-1];
    if (k == DW + 1 && FB == DW + 3) return ^m_byte;
    return 1'b1;
  endfunction
  task automatic step(input logic r, input logic p, input logic [DW-1:0] d);
    bit pop;
    rst = r; i_push = p; i_data = d;
    @(posedge clk);
    cyc++;
    if (!r) begin
      mq.delete(); exp_rx.delete(); m_act = 0; m_ovf = 0;
    end else begin
      pop = mq.size() > 0 && (!m_act || cyc >= m_p + FL + 1);
      if (pop) begin
        m_byte = mq.pop_front(); m_p = cyc; m_act = 1; exp_rx.push_back(m_byte);
      end
      if (p) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1;
      end
    end
    #1;
    chk("tx", o_tx, model_tx());
    chk("busy", o_busy, m_act && cyc - m_p < FL);
    chk("full", o_full, mq.size() == DEPTH);
    chk("empty", o_empty, mq.size() == 0);
    chk("ovf", o_overflow, m_ovf);
    if (!r) rx_on = 0;
    else if (!rx_on) begin
      if (o_tx === 1'b0) begin rx_on = 1; rx_t = 0; end
    end else begin
      rx_t++;
      if (rx_t % DIV == DIV / 2 && rx_t / DIV >= 1 && rx_t / DIV <= DW) rx_b[rx_t/DIV-1] = o_tx;
      if (rx_t == FL - 1) begin
        rx_on = 0; rx_n++; rx_last = rx_b;
        if (exp_rx.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_spurious cyc=%0d actual=%0h required=none", cyc, rx_b);
        end else chk("rx_byte", rx_b, exp_rx.pop_front());
      end
    end
  endtask
  task automatic run_until(input int c);
    while (cyc < c) step(1, 0, DW'($urandom));
  endtask
  task automatic wait_frames(input string name, input int n, input int bound);
    int t = 0;
    while (rx_n < n && t < bound) begin step(1, 0, DW'($urandom)); t++; end
    chk(name, rx_n, n);
  endtask
  task automatic do_reset();
    repeat (3) step(0, 0, DW'($urandom));
    step(1, 0, '0);
  endtask
  initial begin
    int n0, base;
    tv.push_back('{0, 1, 0, 0});  tv.push_back('{1, 0, 1, 1});  tv.push_back('{10, 0, 1, 1});
    tv.push_back('{11, 0, 1, 1}); tv.push_back('{21, 0, 1, 1}); tv.push_back('{31, 1, 1, 1});
    tv.push_back('{41, 0, 1, 1}); tv.push_back('{51, 1, 1, 1}); tv.push_back('{61, 1, 1, 1});
    tv.push_back('{71, 1, 1, 1}); tv.push_back('{81, 0, 1, 1}); tv.push_back('{90, 0, 1, 1});
    tv.push_back('{91, (FB == DW + 3) ? 1'b0 : 1'b1, 1, 1});
    tv.push_back('{FL, 1, 1, 1}); tv.push_back('{FL + 1, 1, 0, 1});
    repeat (3) step(0, 0, DW'($urandom));
    chk("rst_tx", o_tx, 1); chk("rst_empty", o_empty, 1); chk("rst_full", o_full, 0);
    chk("rst_busy", o_busy, 0); chk("rst_ovf", o_overflow, 0);
    step(1, 0, '0);
    step(1, 1, 8'h74);
    n0 = cyc;
    foreach (tv[i]) begin
      run_until(n0 + tv[i].off);
      chk("sb_tx", o_tx, tv[i].tx);
      chk("sb_busy", o_busy, tv[i].busy);
      chk("sb_empty", o_empty, tv[i].empty);
    end
    chk("sb_byte", rx_last, 8'h74);
    run_until(cyc + 3);
    step(1, 1, 8'h74);
    n0 = cyc;
    step(1, 1, 8'h65);
    chk("b2b_empty_q", o_empty, 0);
    run_until(n0 + FL + 1);
    chk("b2b_gap_tx", o_tx, 1); chk("b2b_gap_busy", o_busy, 0);
    step(1, 0, '0);
    chk("b2b_start", o_tx, 0); chk("b2b_empty", o_empty, 1);
    base = rx_n;
    wait_frames("b2b_frames", base + 1, FL + 10);
    chk("b2b_byte", rx_last, 8'h65);
    do_reset();
    base = rx_n;
    for (int i = 0; i < 18; i++) begin
      step(1, 1, DW'($urandom));
      if (i == 16) begin chk("ovf_full", o_full, 1); chk("ovf_pre", o_overflow, 0); end
      if (i == 17) chk("ovf_set", o_overflow, 1);
    end
    wait_frames("ovf_frames", base + 17, 17 * (FL + 2) + 20);
    chk("ovf_sticky", o_overflow, 1);
    chk("ovf_drained", o_empty, 1);
    do_reset();
    chk("ovf_cleared", o_overflow, 0);
    base = rx_n;
    step(1, 1, DW'($urandom));
    n0 = cyc;
    for (int i = 0; i < 16; i++) step(1, 1, DW'($urandom));
    chk("fp_full_pre", o_full, 1);
    run_until(n0 + FL + 1);
    step(1, 1, 8'hC3);
    chk("fp_full", o_full, 1); chk("fp_ovf", o_overflow, 0); chk("fp_busy", o_busy, 1);
    wait_frames("fp_frames", base + 18, 18 * (FL + 2) + 20);
    chk("fp_last", rx_last, 8'hC3);
    do_reset();
    step(1, 1, 8'hA5);
    n0 = cyc;
    run_until(n0 + 1 + 44);
    chk("rmf_in_frame", o_busy, 1);
    step(0, 0, '0);
    chk("rmf_tx", o_tx, 1); chk("rmf_empty", o_empty, 1); chk("rmf_busy", o_busy, 0);
    step(1, 0, '0);
    base = rx_n;
    step(1, 1, 8'h3C);
    wait_frames("rmf_frames", base + 1, FL + 10);
    chk("rmf_byte", rx_last, 8'h3C);
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1, $urandom_range(0, 99) < 2, DW'($urandom));
    for (int t = 0; t < 20 * (FL + 2) && (!o_empty || o_busy); t++) step(1, 0, '0);
    chk("rnd_drained", exp_rx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
